// File: rtl/nn_ctrl_pkg.sv
// Shared definitions for the neural-network layer/weight/activation sequencers.
package nn_ctrl_pkg;

   localparam int ADDR_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } seqState_e;

endpackage

// File: rtl/weight_seq_ctrl.sv
// Walks the weight ROMs and activation buffer through one neuron-layer pass,
// hiding the ROM read latency and streaming valid/ready beats to the MAC array.
module weight_seq_ctrl
   import nn_ctrl_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int MAX_LEN = 784,
   parameter int LAT     = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] len,
   input  logic              abort,
   output logic [ADDR_W-1:0] addr_rd,
   output logic              mac_valid,
   output logic              mac_first,
   output logic              mac_last,
   input  logic              mac_ready,
   output logic              busy,
   output logic              done
);

   generate
      if (LAT != 1) begin : gLatCheck
         $error("weight_seq_ctrl supports only LAT == 1");
      end
   endgenerate

   localparam logic [ADDR_W-1:0] MaxLen = ADDR_W'(MAX_LEN);
   localparam logic [ADDR_W-1:0] One    = ADDR_W'(1);

   seqState_e         state_q;
   logic [ADDR_W-1:0] len_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] beatIdx_q;
   logic              macValid_q;
   logic              macFirst_q;
   logic              macLast_q;
   logic              busy_q;
   logic              done_q;

   logic [ADDR_W-1:0] lenClamp_d;
   logic [ADDR_W-1:0] lenM1_d;
   logic [ADDR_W-1:0] beatNext_d;
   logic              xfer_d;

   always_comb begin
      lenClamp_d = (len > MaxLen) ? MaxLen : len;
      lenM1_d    = (len_q != '0) ? (len_q - One) : '0;
      beatNext_d = beatIdx_q + One;
      xfer_d     = macValid_q && mac_ready;
   end

   // addr_q runs one beat ahead of beatIdx_q so the registered ROM output lines up with the beat.
   always_ff @(posedge clk) begin
      done_q <= 1'b0;
      if (rst) begin
         state_q    <= IDLE;
         len_q      <= '0;
         addr_q     <= '0;
         beatIdx_q  <= '0;
         macValid_q <= 1'b0;
         macFirst_q <= 1'b0;
         macLast_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else if (abort) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         beatIdx_q  <= '0;
         macValid_q <= 1'b0;
         macFirst_q <= 1'b0;
         macLast_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               addr_q <= '0;
               if (start) begin
                  len_q     <= lenClamp_d;
                  beatIdx_q <= '0;
                  if (lenClamp_d != '0) begin
                     state_q <= FILL;
                     busy_q  <= 1'b1;
                  end else begin
                     done_q  <= 1'b1;
                  end
               end
            end
            FILL: begin
               macValid_q <= 1'b1;
               macFirst_q <= 1'b1;
               macLast_q  <= (len_q == One);
               if (len_q > One) begin
                  addr_q <= One;
               end
               state_q <= RUN;
            end
            RUN: begin
               if (xfer_d) begin
                  beatIdx_q  <= beatNext_d;
                  macFirst_q <= 1'b0;
                  if (macLast_q) begin
                     macValid_q <= 1'b0;
                     macLast_q  <= 1'b0;
                     busy_q     <= 1'b0;
                     done_q     <= 1'b1;
                     addr_q     <= '0;
                     state_q    <= IDLE;
                  end else begin
                     macLast_q <= (beatNext_d == lenM1_d);
                     if (addr_q < lenM1_d) begin
                        addr_q <= addr_q + One;
                     end
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign addr_rd   = addr_q;
   assign mac_valid = macValid_q;
   assign mac_first = macFirst_q;
   assign mac_last  = macLast_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
